// File: rtl/seq_ripple_adder.sv
// Bit-serial adder/subtractor: one full-adder slice and a carry register process
// one bit per clock, LSB first, producing SUM/COUT/OVF after WIDTH cycles.
module seq_ripple_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             START,
    input  logic             MODE,
    input  logic             CIN,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] SUM,
    output logic             COUT,
    output logic             OVF,
    output logic             BUSY,
    output logic             DONE
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StFin} state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic [CntW-1:0]  cnt_q;
    logic             carry_q, cout_q, ovf_q, busy_q, done_q;

    logic [WIDTH-1:0] bit_mask;
    logic             a_bit, b_bit, s_bit, c_bit;

    // One-hot select of the bit under processing avoids variable bit-select widths.
    always_comb begin
        bit_mask = WIDTH'(1) << cnt_q;
        a_bit    = |(a_q & bit_mask);
        b_bit    = |(b_q & bit_mask);
        s_bit    = a_bit ^ b_bit ^ carry_q;
        c_bit    = (a_bit & b_bit) | (carry_q & (a_bit ^ b_bit));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                StIdle, StFin: begin
                    done_q <= 1'b0;
                    if (START) begin
                        state_q <= StRun;
                        busy_q  <= 1'b1;
                        a_q     <= A;
                        b_q     <= B ^ {WIDTH{MODE}};
                        carry_q <= CIN ^ MODE;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
                        ovf_q   <= 1'b0;
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StRun: begin
                    sum_q   <= sum_q | (bit_mask & {WIDTH{s_bit}});
                    carry_q <= c_bit;
                    if (cnt_q == LastCnt) begin
                        state_q <= StFin;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cout_q  <= c_bit;
                        // carry_q here is the carry into the MSB
                        ovf_q   <= carry_q ^ c_bit;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign SUM  = sum_q;
    assign COUT = cout_q;
    assign OVF  = ovf_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_seq_ripple_adder.sv
// Self-checking bench for seq_ripple_adder (WIDTH=8): directed cases plus randomized
// operations compared against an integer-arithmetic reference model.
module tb_seq_ripple_adder;

    localparam int unsigned W = 8;

    logic         clk;
    logic         reset;
    logic         START;
    logic         MODE;
    logic         CIN;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic [W-1:0] SUM;
    logic         COUT;
    logic         OVF;
    logic         BUSY;
    logic         DONE;

    int n_cmp = 0;
    int n_err = 0;

    seq_ripple_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .START (START),
        .MODE  (MODE),
        .CIN   (CIN),
        .A     (A),
        .B     (B),
        .SUM   (SUM),
        .COUT  (COUT),
        .OVF   (OVF),
        .BUSY  (BUSY),
        .DONE  (DONE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic void model(input logic mode, input logic cin, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [W-1:0] s,
                                  output logic co, output logic ov);
        int u;
        int r;
        if (!mode) begin
            u = int'(a) + int'(b) + int'(cin);
            r = int'($signed(a)) + int'($signed(b)) + int'(cin);
        end else begin
            u = int'(a) + (255 - int'(b)) + (1 - int'(cin));
            r = int'($signed(a)) - int'($signed(b)) - int'(cin);
        end
        s  = W'(u);
        co = (u >= 256);
        ov = (r < -128) || (r > 127);
    endfunction

    // Called at a negedge; returns at the negedge after the DONE cycle.
    task automatic do_op(input logic mode, input logic cin, input logic [W-1:0] a,
                         input logic [W-1:0] b, input bit noise);
        logic [W-1:0] es;
        logic         ec, eo;
        int           busy_cnt;
        int           waited;
        model(mode, cin, a, b, es, ec, eo);
        START = 1'b1; MODE = mode; CIN = cin; A = a; B = b;
        @(negedge clk);
        START    = 1'b0;
        busy_cnt = 0;
        waited   = 0;
        while (DONE !== 1'b1 && waited < 30) begin
            if (BUSY === 1'b1) busy_cnt++;
            if (noise) begin
                A = W'($urandom); B = W'($urandom);
                MODE = 1'($urandom); CIN = 1'($urandom); START = 1'($urandom);
            end
            @(negedge clk);
            waited++;
        end
        START = 1'b0;
        check_eq("done_seen", 32'(DONE), 32'd1);
        check_eq("latency", 32'(waited), 32'd8);
        check_eq("busy_cycles", 32'(busy_cnt), 32'd8);
        check_eq("busy_in_fin", 32'(BUSY), 32'd0);
        check_eq("sum", 32'(SUM), 32'(es));
        check_eq("cout", 32'(COUT), 32'(ec));
        check_eq("ovf", 32'(OVF), 32'(eo));
        @(negedge clk);
        check_eq("done_pulse", 32'(DONE), 32'd0);
        check_eq("sum_hold", 32'(SUM), 32'(es));
        check_eq("cout_hold", 32'(COUT), 32'(ec));
    endtask

    initial begin
        int gap;
        reset = 1'b1; START = 1'b1; MODE = 1'b0; CIN = 1'b0; A = 8'h12; B = 8'h34;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", 32'(BUSY), 32'd0);
        check_eq("rst_done", 32'(DONE), 32'd0);
        check_eq("rst_sum", 32'(SUM), 32'd0);
        check_eq("rst_flags", 32'({COUT, OVF}), 32'd0);
        reset = 1'b0; START = 1'b0;
        @(negedge clk);
        check_eq("start_during_reset", 32'(BUSY), 32'd0);

        // Directed cases
        do_op(1'b0, 1'b0, 8'h7F, 8'h01, 1'b0);
        do_op(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
        do_op(1'b1, 1'b0, 8'h05, 8'h07, 1'b0);
        do_op(1'b1, 1'b0, 8'h80, 8'h01, 1'b1);

        // Back-to-back with START held high
        START = 1'b1; MODE = 1'b0; CIN = 1'b0; A = 8'h10; B = 8'h20;
        gap = 0;
        do begin @(negedge clk); gap++; end while (DONE !== 1'b1 && gap < 30);
        check_eq("b2b_sum0", 32'(SUM), 32'h30);
        A = 8'h01; B = 8'h01;
        gap = 0;
        do begin @(negedge clk); gap++; end while (DONE !== 1'b1 && gap < 30);
        START = 1'b0;
        check_eq("b2b_gap", 32'(gap), 32'd9);
        check_eq("b2b_sum1", 32'(SUM), 32'h02);
        @(negedge clk);
        check_eq("b2b_idle", 32'({BUSY, DONE}), 32'd0);

        // Reset in the middle of an operation
        START = 1'b1; A = 8'hAA; B = 8'h55; MODE = 1'b0; CIN = 1'b0;
        @(negedge clk);
        START = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        check_eq("abort_sum", 32'(SUM), 32'd0);
        check_eq("abort_busy", 32'(BUSY), 32'd0);
        check_eq("abort_flags", 32'({COUT, OVF, DONE}), 32'd0);
        gap = 0;
        repeat (3) begin @(negedge clk); if (DONE === 1'b1) gap++; end
        reset = 1'b0;
        repeat (10) begin @(negedge clk); if (DONE === 1'b1) gap++; end
        check_eq("abort_no_done", 32'(gap), 32'd0);
        do_op(1'b0, 1'b0, 8'h01, 8'h02, 1'b0);

        // Randomized operations, half of them with input noise during RUN
        for (int i = 0; i < 40; i++) begin
            do_op(1'($urandom), 1'($urandom), W'($urandom), W'($urandom), 1'(i % 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_ripple_adder.md
SEQ_RIPPLE_ADDER -- requirements
Module: seq_ripple_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 2..32.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high; clears all state immediately, independent of clk.
REQ-004 Port: START  input  1  request a new operation; sampled on rising edge.
REQ-005 Port: MODE  input  1  0 = add (A+B+CIN), 1 = subtract (A-B-CIN); latched at accepted START.
REQ-006 Port: CIN  input  1  carry-in (add) or borrow-in (subtract); latched at accepted START.
REQ-007 Port: A  input  WIDTH  operand A; latched at accepted START.
REQ-008 Port: B  input  WIDTH  operand B; latched at accepted START.
REQ-009 Port: SUM  output  WIDTH  result, LSB computed first; valid while DONE=1 and held until next accepted START.
REQ-010 Port: COUT  output  1  carry out of MSB stage (subtract: 1 = no borrow); valid/held with SUM.
REQ-011 Port: OVF  output  1  signed two's-complement overflow; valid/held with SUM.
REQ-012 Port: BUSY  output  1  high while operation in progress (state RUN).
REQ-013 Port: DONE  output  1  one-cycle pulse marking result valid (state FIN).

Function
REQ-014 Block SHALL compute one bit per clock with a single full-adder slice (sum = a^b^c, carry = a&b | c&(a^b)) and a carry register.
REQ-015 FSM SHALL have states IDLE, RUN, FIN; encoding free.
REQ-016 IDLE: START=1 -> RUN; latch A, B^{WIDTH{MODE}} into operand regs, carry reg <= CIN^MODE, bit counter <= 0; else stay IDLE.
REQ-017 RUN: each edge processes bit[cnt]: SUM[cnt] <= slice sum, carry reg <= slice carry, cnt <= cnt+1; at cnt=WIDTH-1 -> FIN.
REQ-018 At last bit, OVF SHALL be (carry into MSB) XOR (carry out of MSB); COUT SHALL be carry out of MSB.
REQ-019 FIN: DONE=1 for exactly one cycle; START=1 in FIN SHALL be accepted as in IDLE (-> RUN, back-to-back); else -> IDLE.
REQ-020 Latency: START sampled at edge 0 -> BUSY high after edges 0..WIDTH-1, DONE high in the cycle following edge WIDTH; throughput one result per WIDTH+1 cycles.
REQ-021 START while in RUN SHALL be ignored; input changes on A, B, MODE, CIN during RUN SHALL not affect the result.
REQ-022 SUM, COUT, OVF SHALL not be cleared at FIN->IDLE; they hold until the next accepted START clears them to 0 (same edge as RUN entry).
REQ-023 Bit counter width SHALL be clog2(WIDTH)+1; no wrap beyond WIDTH-1 permitted.
REQ-024 Arithmetic is modulo 2^WIDTH; subtract implemented as A + ~B + ~CIN.

Reset
REQ-025 reset=1 SHALL force, asynchronously: state IDLE, cnt 0, carry 0, operand regs 0, SUM 0, COUT 0, OVF 0, BUSY 0, DONE 0.
REQ-026 reset asserted mid-RUN SHALL abort the operation with no DONE pulse; first START after reset release starts a fresh operation.
REQ-027 START coincident with reset SHALL be ignored.

Verification (WIDTH=8)
REQ-028 Add 0x7F+0x01, CIN=0 -> DONE at edge 8 after START, SUM=0x80, COUT=0, OVF=1, BUSY high 8 cycles.
REQ-029 Add 0xFF+0x00, CIN=1 -> SUM=0x00, COUT=1, OVF=0.
REQ-030 Sub 0x05-0x07, CIN=0 -> SUM=0xFE, COUT=0, OVF=0; Sub 0x80-0x01, CIN=0 -> SUM=0x7F, COUT=1, OVF=1.
REQ-031 START held high continuously with 0x10+0x20 then 0x01+0x01 presented in FIN cycle -> DONE pulses 9 cycles apart, SUM=0x30 then 0x02; extra START pulses mid-RUN change nothing.
REQ-032 reset pulse at bit 4 of 0xAA+0x55 -> all outputs 0 immediately, no DONE; subsequent 0x01+0x02 -> SUM=0x03, COUT=0, OVF=0.
